// File: rtl/axis_gearbox_pkg.sv
// rtl/axis_gearbox_pkg.sv - shared keep/count helpers for the byte-granular AXIS gearbox
package axis_gearbox_pkg;

  localparam int MAX_BYTES = 64;

  // Byte count of a packed keep; non-packed keeps are not screened here.
  function automatic int keep_to_count(input logic [MAX_BYTES-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      n += int'(keep[i]);
    end
    return n;
  endfunction

  function automatic logic [MAX_BYTES-1:0] count_to_keep(input int n, input int width);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      k[i] = (i < n) && (i < width);
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_gearbox.sv
// rtl/axis_gearbox.sv - AXIS width converter for arbitrary input/output byte widths
module axis_gearbox
  import axis_gearbox_pkg::*;
#(
  parameter int AXIS_I_BYTES = 3,
  parameter int AXIS_O_BYTES = 2,
  parameter int BUF_BYTES    = AXIS_I_BYTES + AXIS_O_BYTES
) (
  input  logic                      clk,
  input  logic                      sresetn,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_I_BYTES-1:0]   axis_i_tkeep,
  input  logic [8*AXIS_I_BYTES-1:0] axis_i_tdata,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_O_BYTES-1:0]   axis_o_tkeep,
  output logic [8*AXIS_O_BYTES-1:0] axis_o_tdata
);

  localparam int FW = $clog2(BUF_BYTES + 1);
  localparam int BW = 8 * BUF_BYTES;
  localparam logic [FW-1:0] I_ROOM = FW'(BUF_BYTES - AXIS_I_BYTES);
  localparam logic [FW-1:0] O_FILL = FW'(AXIS_O_BYTES);

  if (AXIS_I_BYTES < 1 || AXIS_O_BYTES < 1 ||
      AXIS_I_BYTES > MAX_BYTES || AXIS_O_BYTES > MAX_BYTES) begin : g_bad_width
    $error("axis_gearbox: byte widths must be in 1..%0d", MAX_BYTES);
  end
  if (BUF_BYTES < AXIS_I_BYTES + AXIS_O_BYTES) begin : g_bad_buf
    $error("axis_gearbox: BUF_BYTES must be >= AXIS_I_BYTES + AXIS_O_BYTES");
  end

  logic [BW-1:0]             buf_q, buf_next, ins_data, ins_mask;
  logic [8*AXIS_I_BYTES-1:0] in_mask;
  logic [FW-1:0]             fill_q, fill_next, pop, n_in, wr_base;
  logic                      last_pend_q, last_pend_next;
  logic                      i_fire, o_fire;

  for (genvar g = 0; g < AXIS_I_BYTES; g++) begin : g_in_mask
    assign in_mask[8*g +: 8] = {8{axis_i_tkeep[g]}};
  end

  // Ready depends only on registered state so no o_tready -> i_tready path exists.
  assign axis_i_tready = sresetn && !last_pend_q && (fill_q <= I_ROOM);
  assign axis_o_tvalid = sresetn && ((fill_q >= O_FILL) || last_pend_q);
  assign axis_o_tlast  = sresetn && last_pend_q && (fill_q <= O_FILL);
  assign axis_o_tkeep  = sresetn ? AXIS_O_BYTES'(count_to_keep(int'(fill_q), AXIS_O_BYTES)) : '0;
  assign axis_o_tdata  = buf_q[8*AXIS_O_BYTES-1:0];

  // Pop shifts the buffer down; new bytes land right after the survivors.
  always_comb begin
    i_fire         = axis_i_tvalid && axis_i_tready;
    o_fire         = axis_o_tvalid && axis_o_tready;
    n_in           = i_fire ? FW'(keep_to_count(MAX_BYTES'(axis_i_tkeep))) : '0;
    pop            = '0;
    if (o_fire) begin
      pop = (fill_q >= O_FILL) ? O_FILL : fill_q;
    end
    wr_base        = fill_q - pop;
    ins_data       = BW'(axis_i_tdata & in_mask) << {wr_base, 3'b000};
    ins_mask       = i_fire ? (BW'(in_mask) << {wr_base, 3'b000}) : '0;
    buf_next       = ((buf_q >> {pop, 3'b000}) & ~ins_mask) | (ins_data & ins_mask);
    fill_next      = fill_q - pop + n_in;
    last_pend_next = last_pend_q;
    if (o_fire && axis_o_tlast) begin
      last_pend_next = 1'b0;
    end
    if (i_fire && axis_i_tlast) begin
      last_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_next;
    if (!sresetn) begin
      fill_q      <= '0;
      last_pend_q <= 1'b0;
    end else begin
      fill_q      <= fill_next;
      last_pend_q <= last_pend_next;
    end
  end

endmodule

// File: tb/tb_axis_gearbox.sv
// tb/tb_axis_gearbox.sv - scoreboard bench over four width pairs of axis_gearbox
module tb_axis_gearbox;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic        i_valid[4], i_last[4], i_ready[4];
  logic        o_ready[4], o_valid[4], o_last[4];
  logic [7:0]  i_keep[4], o_keep[4];
  logic [63:0] i_data[4], o_data[4];
  logic [15:0] od0;
  logic [23:0] od1;
  logic [31:0] od2;
  logic [63:0] od3;
  logic [1:0]  ok0;
  logic [2:0]  ok1;
  logic [3:0]  ok2;
  logic [7:0]  ok3;

  int    n_cmp = 0;
  int    n_err = 0;
  int    mode[4];
  beat_t exp_q[4][$];
  logic  stall[4];
  beat_t held[4];

  always #5 clk = ~clk;

  assign o_data[0] = 64'(od0);
  assign o_data[1] = 64'(od1);
  assign o_data[2] = 64'(od2);
  assign o_data[3] = od3;
  assign o_keep[0] = 8'(ok0);
  assign o_keep[1] = 8'(ok1);
  assign o_keep[2] = 8'(ok2);
  assign o_keep[3] = ok3;

  axis_gearbox #(.AXIS_I_BYTES(3), .AXIS_O_BYTES(2)) u_3to2 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(i_ready[0]), .axis_i_tvalid(i_valid[0]), .axis_i_tlast(i_last[0]),
    .axis_i_tkeep(i_keep[0][2:0]), .axis_i_tdata(i_data[0][23:0]),
    .axis_o_tready(o_ready[0]), .axis_o_tvalid(o_valid[0]), .axis_o_tlast(o_last[0]),
    .axis_o_tkeep(ok0), .axis_o_tdata(od0));

  axis_gearbox #(.AXIS_I_BYTES(2), .AXIS_O_BYTES(3)) u_2to3 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(i_ready[1]), .axis_i_tvalid(i_valid[1]), .axis_i_tlast(i_last[1]),
    .axis_i_tkeep(i_keep[1][1:0]), .axis_i_tdata(i_data[1][15:0]),
    .axis_o_tready(o_ready[1]), .axis_o_tvalid(o_valid[1]), .axis_o_tlast(o_last[1]),
    .axis_o_tkeep(ok1), .axis_o_tdata(od1));

  axis_gearbox #(.AXIS_I_BYTES(4), .AXIS_O_BYTES(4)) u_4to4 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(i_ready[2]), .axis_i_tvalid(i_valid[2]), .axis_i_tlast(i_last[2]),
    .axis_i_tkeep(i_keep[2][3:0]), .axis_i_tdata(i_data[2][31:0]),
    .axis_o_tready(o_ready[2]), .axis_o_tvalid(o_valid[2]), .axis_o_tlast(o_last[2]),
    .axis_o_tkeep(ok2), .axis_o_tdata(od2));

  axis_gearbox #(.AXIS_I_BYTES(5), .AXIS_O_BYTES(8)) u_5to8 (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(i_ready[3]), .axis_i_tvalid(i_valid[3]), .axis_i_tlast(i_last[3]),
    .axis_i_tkeep(i_keep[3][4:0]), .axis_i_tdata(i_data[3][39:0]),
    .axis_o_tready(o_ready[3]), .axis_o_tvalid(o_valid[3]), .axis_o_tlast(o_last[3]),
    .axis_o_tkeep(ok3), .axis_o_tdata(od3));

  function automatic int ib_of(input int k);
    case (k)
      0: return 3;
      1: return 2;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int ob_of(input int k);
    case (k)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] kmask(input logic [7:0] keep);
    logic [63:0] m;
    for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{keep[j]}};
    return m;
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) begin
      mode[k] = 1; o_ready[k] = 1'b1; stall[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
        o_ready[k] = (mode[k] == 2) ? 1'($urandom_range(0, 1)) : (mode[k] == 1);
    end
  end

  // Scoreboard: every output transfer is popped and compared; stalled beats must hold.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      beat_t got, want;
      got.data = o_data[k] & kmask(o_keep[k]);
      got.keep = o_keep[k];
      got.last = o_last[k];
      if (!sresetn) begin
        stall[k] = 1'b0;
      end else begin
        if (stall[k]) begin
          n_cmp++;
          if (o_valid[k] !== 1'b1 || got !== held[k]) begin
            n_err++;
            $display("FAIL stall_hold inst=%0d got v=%b %h/%h/%b want v=1 %h/%h/%b", k, o_valid[k],
                     got.data, got.keep, got.last, held[k].data, held[k].keep, held[k].last);
          end
        end
        if (o_valid[k] === 1'b1 && o_ready[k] === 1'b1) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_err++;
            $display("FAIL extra_beat inst=%0d got data=%h keep=%h last=%b want none", k,
                     got.data, got.keep, got.last);
          end else begin
            want = exp_q[k].pop_front();
            want.data = want.data & kmask(want.keep);
            if (got !== want) begin
              n_err++;
              $display("FAIL beat inst=%0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                       k, got.data, got.keep, got.last, want.data, want.keep, want.last);
            end
          end
        end
        stall[k] = (o_valid[k] === 1'b1) && (o_ready[k] !== 1'b1);
        held[k]  = got;
      end
    end
  end

  task automatic send_packet(input int k, input bq_t b);
    int    n, pos, take, cnt, ib, ob;
    beat_t e;
    n  = b.size();
    ib = ib_of(k);
    ob = ob_of(k);
    if (n == 0) begin
      e = '0; e.last = 1'b1;
      exp_q[k].push_back(e);
    end
    for (int s = 0; s < n; s += ob) begin
      e = '0;
      for (int j = 0; j < ob && s + j < n; j++) begin
        e.data[8*j +: 8] = b[s+j];
        e.keep[j] = 1'b1;
      end
      e.last = (s + ob >= n);
      exp_q[k].push_back(e);
    end
    pos = 0;
    do begin
      take = (n - pos > ib) ? ib : n - pos;
      i_data[k] = '0;
      i_keep[k] = '0;
      for (int j = 0; j < take; j++) begin
        i_data[k][8*j +: 8] = b[pos+j];
        i_keep[k][j] = 1'b1;
      end
      pos += take;
      i_last[k]  = (pos == n);
      i_valid[k] = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (i_ready[k] !== 1'b1 && cnt < 2000) begin
        @(negedge clk);
        cnt++;
      end
      if (i_ready[k] !== 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL in_ready_timeout inst=%0d got=%b want=1", k, i_ready[k]);
      end
      @(posedge clk);
      #1;
    end while (pos < n);
    i_valid[k] = 1'b0;
    i_last[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    int cnt;
    cnt = 0;
    while (exp_q[k].size() != 0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({i_ready[k], o_valid[k], o_last[k], o_keep[k]} !== 11'b0) begin
        n_err++;
        $display("FAIL reset_outputs inst=%0d got rdy=%b v=%b l=%b keep=%h want 0/0/0/00",
                 k, i_ready[k], o_valid[k], o_last[k], o_keep[k]);
      end
    end
    @(posedge clk);
    #1 sresetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (i_ready[k] !== 1'b1 || o_valid[k] !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset inst=%0d got rdy=%b v=%b want rdy=1 v=0", k, i_ready[k], o_valid[k]);
      end
    end
  endtask

  task automatic test_3to2();
    bq_t b;
    b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    @(posedge clk); #1;
    send_packet(0, b);
    send_packet(0, b);
    drain(0);
    n_cmp++;
    if (exp_q[0].size() != 0) begin
      n_err++;
      $display("FAIL 3to2_drain got=%0d left want=0", exp_q[0].size());
    end
  endtask

  task automatic test_2to3();
    bq_t b;
    b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    @(posedge clk); #1;
    send_packet(1, b);
    drain(1);
    n_cmp++;
    if (exp_q[1].size() != 0) begin
      n_err++;
      $display("FAIL 2to3_drain got=%0d left want=0", exp_q[1].size());
    end
  endtask

  task automatic test_zero_tlast();
    bq_t b;
    b = {};
    mode[0] = 0;
    @(posedge clk); #1;
    send_packet(0, b);
    @(negedge clk);
    n_cmp++;
    if (o_valid[0] !== 1'b1 || o_keep[0] !== 8'h00 || o_last[0] !== 1'b1) begin
      n_err++;
      $display("FAIL zero_tlast_beat got v=%b keep=%h l=%b want v=1 keep=00 l=1",
               o_valid[0], o_keep[0], o_last[0]);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (i_ready[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zero_tlast_block got rdy=%b want 0", i_ready[0]);
    end
    mode[0] = 1;
    drain(0);
    n_cmp++;
    if (exp_q[0].size() != 0 || i_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL zero_tlast_release got left=%0d rdy=%b want 0/1", exp_q[0].size(), i_ready[0]);
    end
  endtask

  task automatic test_random_4to4();
    bq_t b;
    int  len;
    mode[2] = 2;
    @(posedge clk); #1;
    for (int p = 0; p < 100; p++) begin
      b = {};
      len = $urandom_range(0, 12);
      for (int j = 0; j < len; j++) b.push_back(8'($urandom_range(0, 255)));
      send_packet(2, b);
    end
    drain(2);
    mode[2] = 1;
    n_cmp++;
    if (exp_q[2].size() != 0) begin
      n_err++;
      $display("FAIL 4to4_drain got=%0d left want=0", exp_q[2].size());
    end
  endtask

  task automatic test_reset_mid_packet();
    bq_t b;
    mode[0] = 0;
    @(posedge clk); #1;
    i_data[0] = 64'h0000_0000_00cc_bbaa;
    i_keep[0] = 8'h07;
    i_last[0] = 1'b0;
    i_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    i_valid[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_valid[0] !== 1'b1 || o_keep[0] !== 8'h03) begin
      n_err++;
      $display("FAIL mid_pre_reset got v=%b keep=%h want v=1 keep=03", o_valid[0], o_keep[0]);
    end
    @(posedge clk); #1 sresetn = 1'b0;
    @(posedge clk); #1 sresetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_valid[0] !== 1'b0 || i_ready[0] !== 1'b1 || o_keep[0] !== 8'h00) begin
      n_err++;
      $display("FAIL mid_post_reset got v=%b rdy=%b keep=%h want v=0 rdy=1 keep=00",
               o_valid[0], i_ready[0], o_keep[0]);
    end
    mode[0] = 1;
    b = '{8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'ha4};
    @(posedge clk); #1;
    send_packet(0, b);
    drain(0);
    n_cmp++;
    if (exp_q[0].size() != 0) begin
      n_err++;
      $display("FAIL mid_next_packet got=%0d left want=0", exp_q[0].size());
    end
  endtask

  task automatic test_5to8_backpressure();
    bq_t b;
    b = {};
    for (int j = 0; j < 15; j++) b.push_back(8'(8'h10 + j));
    mode[3] = 0;
    @(posedge clk); #1;
    fork
      send_packet(3, b);
      begin
        repeat (6) @(negedge clk);
        n_cmp++;
        if (i_ready[3] !== 1'b0 || o_valid[3] !== 1'b1 || o_keep[3] !== 8'hff) begin
          n_err++;
          $display("FAIL 5to8_full got rdy=%b v=%b keep=%h want rdy=0 v=1 keep=ff",
                   i_ready[3], o_valid[3], o_keep[3]);
        end
        mode[3] = 1;
      end
    join
    drain(3);
    n_cmp++;
    if (exp_q[3].size() != 0) begin
      n_err++;
      $display("FAIL 5to8_drain got=%0d left want=0", exp_q[3].size());
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      i_valid[k] = 1'b0; i_last[k] = 1'b0; i_keep[k] = '0; i_data[k] = '0;
    end
    test_reset();
    test_3to2();
    test_2to3();
    test_zero_tlast();
    test_random_4to4();
    test_reset_mid_packet();
    test_5to8_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
